camera_capture: RTL and testbench
=================================

# camera_capture

Pixel capture stage directly downstream of the OV7670 SCCB initialisation block. Once the camera is configured (RGB444, xR GB byte order, PCLK gated during horizontal blank), this block oversamples the camera's parallel bus in the clk_100MHz domain. It assembles byte pairs into 12-bit RGB444 pixels and issues one write per pixel, with a linear frame-buffer address, to the downstream frame buffer.

## Interface

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- ADDR_W, 19, width of pix_addr; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- clk_100MHz  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- init_done  in  1  level, high once camera register initialisation is complete
- cam_pclk  in  1  camera pixel clock, ≤ 25 MHz, asynchronous
- cam_vsync  in  1  camera vertical sync, high during vertical blank
- cam_href  in  1  camera line-valid, high during active bytes
- cam_data  in  8  camera data byte
- pix_valid  out  1  one-cycle write strobe
- pix_addr  out  ADDR_W  y*WIDTH + x of the pixel
- pix_data  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse at end of each captured frame
- status  out  2  current FSM state, for debug

## Operation

- Input conditioning:
  - cam_pclk, cam_vsync, cam_href and cam_data pass through a 2-flop synchroniser (the data bus uses the same stages).
  - A third pclk flop provides edge detection.
  - All logic acts on a pclk rising edge seen in synchronised form (pclk_rise).
  - vsync rise and fall, and href fall, are detected the same way.
- FSM states:
  - WAIT_INIT (0): stays here while init_done=0; goes to WAIT_FRAME when init_done=1.
  - WAIT_FRAME (1): waits for a vsync falling edge, then clears x, y, line_base and phase and goes to CAPTURE. This guarantees capture starts on a frame boundary.
  - CAPTURE (2): on a vsync rising edge, pulses frame_done and returns to WAIT_FRAME.
  - If init_done drops in any state, go to WAIT_INIT; no frame_done is issued.
- Byte assembly, in CAPTURE, on pclk_rise with href=1:
  - phase=0: latch cam_data[3:0] as R and set phase=1.
  - phase=1: form pix_data={R,cam_data[7:4],cam_data[3:0]} and set phase=0.
  - If x<WIDTH and y<HEIGHT, assert pix_valid with pix_addr=line_base+x. x increments in either case, saturating at WIDTH.
- Line end (href fall in CAPTURE):
  - phase clears; an odd trailing byte is discarded.
  - If x≠0: x=0, y+1 (saturating at HEIGHT), line_base+=WIDTH (added only while y<HEIGHT).
  - Width rules: no multiplier; line_base and pix_addr are ADDR_W bits, x is clog2(WIDTH+1) bits, y is clog2(HEIGHT+1) bits.
- Pixels beyond WIDTH per line, and lines beyond HEIGHT, are dropped silently with no address wrap. Short lines and short frames are accepted as received.

## Timing

- Reset values: pix_valid=0, pix_addr=0, pix_data=0, frame_done=0, status=0 (WAIT_INIT); all counters and phase are 0.
- Latency: a camera pclk rising edge produces pclk_rise 3 clk_100MHz cycles later. pix_valid is registered and asserts on the cycle after pclk_rise of the second byte. pix_addr and pix_data are valid only while pix_valid=1 and hold their values otherwise.
- No backpressure: the consumer must accept one write per cycle. The minimum pix_valid spacing is 8 cycles at 25 MHz pclk.
- If a vsync fall and a pclk_rise occur in the same cycle, the vsync action wins and that byte is ignored.
- If an href fall and a pclk_rise occur in the same cycle, the byte is ignored; the line-end action takes effect.
- frame_done asserts 1 cycle after the vsync rise is detected and lasts exactly 1 cycle.
- Asserting rst_n mid-frame clears outputs immediately. Capture then resumes only at the next vsync falling edge after init_done.

## Structure

- A shared package, camera_pkg, holds the FSM state encodings (WAIT_INIT=0, WAIT_FRAME=1, CAPTURE=2) and the OV7670 default WIDTH and HEIGHT constants. The SCCB init block uses the same package.
- One sub-module: cam_sync, a parameterised N-bit 2-flop synchroniser plus a registered previous-value output for edge detection. It is instantiated once for the 11-bit bundle {pclk,vsync,href,data}.

## Test plan

- Camera model with WIDTH=4, HEIGHT=2 and init_done held 0, driving a full frame -> no pix_valid. Raise init_done mid-frame -> still no capture until the next vsync fall.
- Normal frame, byte pairs (0x0A,0xBC) -> pix_data=0xABC, pix_addr sequence 0..7, exactly 8 pix_valid strobes, then one frame_done pulse.
- Line of 6 pixels with WIDTH=4 -> only addresses 0..3 written; the next line starts at address 4.
- Line with an odd byte count of 5 -> 2 pixels written; the trailing byte is dropped; the next line's first pixel is assembled correctly.
- 3 lines with HEIGHT=2 -> third line dropped; no address ≥ 8; frame_done still pulses once.
- rst_n asserted mid-line -> outputs 0 immediately; after release, the first pix_valid carries pix_addr=0 from the next frame.

Source files
------------

// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared OV7670 capture constants and FSM state encodings
package camera_pkg;

    // Capture FSM states; the numeric values are exported on the status port.
    typedef enum logic [1:0] {
        WAIT_INIT  = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } cap_state_t;

    // OV7670 VGA defaults.
    localparam int OV_WIDTH  = 640;
    localparam int OV_HEIGHT = 480;

    // RGB444 pixel width {R,G,B}.
    localparam int PIX_W = 12;

endpackage

// File: rtl/camera_capture_if.sv
// rtl/camera_capture_if.sv - pixel write bus from capture stage to frame buffer
// Signals:
//   pix_valid  one-cycle write strobe
//   pix_addr   linear frame-buffer address y*WIDTH + x
//   pix_data   {R[3:0],G[3:0],B[3:0]}
// Modports: master (capture side, drives), slave (frame buffer side, receives).
interface camera_capture_if
    import camera_pkg::*;
#(
    parameter int ADDR_W = 19
);
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic [PIX_W-1:0]  pix_data;

    modport master (output pix_valid, pix_addr, pix_data);
    modport slave  (input  pix_valid, pix_addr, pix_data);
endinterface

// File: rtl/cam_sync.sv
// rtl/cam_sync.sv - N-bit two-flop synchroniser with registered previous value
// Ports:
//   clk_100MHz  system clock
//   rst_n       asynchronous active-low reset
//   d           asynchronous input bundle
//   q           synchronised bundle
//   q_prev      q delayed one cycle, for edge detection
module cam_sync #(
    parameter int N = 11
) (
    input  logic         clk_100MHz,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] q_prev
);

    logic [N-1:0] meta;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            q      <= '0;
            q_prev <= '0;
        end else begin
            meta   <= d;
            q      <= meta;
            q_prev <= q;
        end
    end

endmodule

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - OV7670 RGB444 pixel capture into linear frame-buffer writes
// Ports:
//   clk_100MHz  system clock
//   rst_n       asynchronous active-low reset
//   init_done   camera register initialisation complete (level)
//   cam_pclk    camera pixel clock (asynchronous, oversampled)
//   cam_vsync   camera vertical sync, high during vertical blank
//   cam_href    camera line-valid
//   cam_data    camera data byte
//   pix         pixel write bus (master)
//   frame_done  one-cycle pulse at end of each captured frame
//   status      current FSM state
module camera_capture
    import camera_pkg::*;
#(
    parameter int WIDTH  = OV_WIDTH,
    parameter int HEIGHT = OV_HEIGHT,
    parameter int ADDR_W = 19
) (
    input  logic                    clk_100MHz,
    input  logic                    rst_n,
    input  logic                    init_done,
    input  logic                    cam_pclk,
    input  logic                    cam_vsync,
    input  logic                    cam_href,
    input  logic [7:0]              cam_data,
    camera_capture_if.master        pix,
    output logic                    frame_done,
    output logic [1:0]              status
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0]     X_END     = XW'(WIDTH);
    localparam logic [YW-1:0]     Y_END     = YW'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

    // Bundle layout: [10]=pclk [9]=vsync [8]=href [7:0]=data
    logic [10:0] s_q;
    logic [10:0] s_prev;

    cam_sync #(.N(11)) u_sync (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .d          ({cam_pclk, cam_vsync, cam_href, cam_data}),
        .q          (s_q),
        .q_prev     (s_prev)
    );

    logic       pclk_rise, vs_rise, vs_fall, href, href_fall;
    logic [7:0] data;
    logic       sync_prev_unused;

    assign pclk_rise = s_q[10] & ~s_prev[10];
    assign vs_rise   = s_q[9]  & ~s_prev[9];
    assign vs_fall   = ~s_q[9] &  s_prev[9];
    assign href      = s_q[8];
    assign href_fall = ~s_q[8] &  s_prev[8];
    assign data      = s_q[7:0];
    // Only the control bits need edge detection.
    assign sync_prev_unused = ^s_prev[7:0];

    cap_state_t        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic [3:0]        red;

    assign status = state;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_INIT;
            x             <= '0;
            y             <= '0;
            line_base     <= '0;
            phase         <= 1'b0;
            red           <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_addr  <= '0;
            pix.pix_data  <= '0;
            frame_done    <= 1'b0;
        end else begin
            pix.pix_valid <= 1'b0;
            frame_done    <= 1'b0;
            if (!init_done) begin
                // Losing initialisation abandons the frame without frame_done.
                state <= WAIT_INIT;
                phase <= 1'b0;
            end else begin
                case (state)
                    WAIT_INIT: state <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        // Start only on a frame boundary; a coincident byte is ignored.
                        if (vs_fall) begin
                            x         <= '0;
                            y         <= '0;
                            line_base <= '0;
                            phase     <= 1'b0;
                            state     <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            frame_done <= 1'b1;
                            state      <= WAIT_FRAME;
                        end else if (href_fall) begin
                            // Line end wins over a coincident byte; an odd byte is dropped.
                            phase <= 1'b0;
                            if (x != '0) begin
                                x <= '0;
                                if (y < Y_END) begin
                                    y         <= y + 1'b1;
                                    line_base <= line_base + LINE_STEP;
                                end
                            end
                        end else if (pclk_rise && href) begin
                            if (!phase) begin
                                red   <= data[3:0];
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (x < X_END && y < Y_END) begin
                                    pix.pix_valid <= 1'b1;
                                    pix.pix_addr  <= line_base + ADDR_W'(x);
                                    pix.pix_data  <= {red, data};
                                end
                                if (x < X_END) x <= x + 1'b1;
                            end
                        end
                    end
                    default: state <= WAIT_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - self-checking bench for camera_capture with a camera stimulus model
module tb_camera_capture;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    typedef logic [AW+11:0] wr_t;   // {addr, data}

    logic       clk_100MHz = 1'b0;
    logic       rst_n      = 1'b0;
    logic       init_done  = 1'b0;
    logic       cam_pclk   = 1'b0;
    logic       cam_vsync  = 1'b0;
    logic       cam_href   = 1'b0;
    logic [7:0] cam_data   = 8'h00;
    logic       frame_done;
    logic [1:0] status;

    camera_capture_if #(.ADDR_W(AW)) pix_if ();

    camera_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .pix        (pix_if),
        .frame_done (frame_done),
        .status     (status)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    logic [7:0] line_q[$];
    wr_t  exp_q[$];
    wr_t  got_q[$];
    int   got_fd = 0;
    int   exp_fd = 0;
    int   mline  = 0;

    always @(negedge clk_100MHz) begin
        if (pix_if.pix_valid) got_q.push_back({pix_if.pix_addr, pix_if.pix_data});
        if (frame_done) got_fd++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_data = b;
        #20 cam_pclk = 1'b1;
        #20 cam_pclk = 1'b0;
    endtask

    // Drives line_q as one href line; when cap is set, the expected writes follow
    // from the rules: pixel k of the n-th non-empty line lands at n*W+k if k<W, n<H.
    task automatic send_line(input bit cap);
        int   npix;
        logic [AW-1:0] a;
        cam_href = 1'b1;
        #20;
        foreach (line_q[i]) cam_byte(line_q[i]);
        #20 cam_href = 1'b0;
        #60;
        if (cap) begin
            npix = line_q.size() / 2;
            if (npix > 0) begin
                for (int k = 0; k < npix; k++) begin
                    if (k < W && mline < H) begin
                        a = AW'(mline * W + k);
                        exp_q.push_back({a, line_q[2*k][3:0], line_q[2*k+1]});
                    end
                end
                mline++;
            end
        end
        line_q.delete();
    endtask

    task automatic fill_pairs(input int n, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(b0);
            line_q.push_back(b1);
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
    endtask

    task automatic vs_fall();
        cam_vsync = 1'b1;
        #200 cam_vsync = 1'b0;
        #100;
        mline = 0;
    endtask

    task automatic vs_rise(input bit cap);
        cam_vsync = 1'b1;
        #200;
        if (cap) exp_fd++;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i][AW+11:12]), 32'(exp_q[i][AW+11:12]));
            check($sformatf("%s_data%0d", tag, i), 32'(got_q[i][11:0]), 32'(exp_q[i][11:0]));
        end
        check({tag, "_frame_done"}, got_fd, exp_fd);
        got_q.delete();
        exp_q.delete();
        got_fd = 0;
        exp_fd = 0;
    endtask

    initial begin
        int nl;

        // Reset state; stimulus times sit 3 ns past a 10 ns grid, off every clock edge.
        #23;
        check("rst_valid", pix_if.pix_valid, 0);
        check("rst_addr", pix_if.pix_addr, 0);
        check("rst_data", pix_if.pix_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_status", status, 0);
        rst_n = 1'b1;
        #40;

        // Frame while uninitialised: nothing captured.
        vs_fall();
        fill_pairs(4, 8'h0A, 8'hBC); send_line(0);
        fill_pairs(4, 8'h0A, 8'hBC); send_line(0);
        vs_rise(0);
        check("noinit_status", status, 0);
        compare_frame("noinit");

        // init_done rises mid-frame: still no capture until the next vsync fall.
        vs_fall();
        fill_pairs(4, 8'h0A, 8'hBC); send_line(0);
        init_done = 1'b1;
        fill_pairs(4, 8'h0A, 8'hBC); send_line(0);
        vs_rise(0);
        check("midinit_status", status, 1);
        compare_frame("midinit");

        // Normal frame of fixed byte pairs.
        vs_fall();
        check("capture_status", status, 2);
        fill_pairs(4, 8'h0A, 8'hBC); send_line(1);
        fill_pairs(4, 8'h0A, 8'hBC); send_line(1);
        vs_rise(1);
        if (got_q.size() > 0) check("normal_first_data", got_q[0][11:0], 12'hABC);
        else check("normal_first_data", 0, 12'hABC);
        compare_frame("normal");

        // Overlong line: only W pixels written, next line starts at W.
        vs_fall();
        fill_rand(12); send_line(1);
        fill_rand(8);  send_line(1);
        vs_rise(1);
        compare_frame("wide");

        // Odd byte count: trailing byte dropped, next line assembles cleanly.
        vs_fall();
        fill_rand(5); send_line(1);
        fill_rand(8); send_line(1);
        vs_rise(1);
        compare_frame("odd");

        // Too many lines: the third line is dropped.
        vs_fall();
        for (int l = 0; l < 3; l++) begin
            fill_rand(8);
            send_line(1);
        end
        vs_rise(1);
        foreach (got_q[i]) check("tall_addr_range", 32'(got_q[i][AW+11:12] < 8), 1);
        compare_frame("tall");

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            vs_fall();
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                fill_rand($urandom_range(0, 13));
                send_line(1);
            end
            vs_rise(1);
            compare_frame($sformatf("rand%0d", f));
        end

        // Reset mid-line: outputs clear at once; capture resumes on the next frame.
        vs_fall();
        fill_rand(8); send_line(1);
        cam_href = 1'b1;
        #20;
        cam_byte(8'h05); cam_byte(8'h67); cam_byte(8'h11);
        check("prerst_addr", pix_if.pix_addr, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", pix_if.pix_valid, 0);
        check("midrst_addr", pix_if.pix_addr, 0);
        check("midrst_data", pix_if.pix_data, 0);
        check("midrst_status", status, 0);
        #49 rst_n = 1'b1;
        #20;
        got_q.delete();
        exp_q.delete();
        got_fd = 0;
        cam_byte(8'h22); cam_byte(8'h33); cam_byte(8'h44);
        #20 cam_href = 1'b0;
        #60;
        vs_rise(0);
        compare_frame("postrst_tail");
        vs_fall();
        fill_rand(8); send_line(1);
        fill_rand(6); send_line(1);
        vs_rise(1);
        if (got_q.size() > 0) check("postrst_first_addr", got_q[0][AW+11:12], 0);
        else check("postrst_first_addr", 32'hFFFF_FFFF, 0);
        compare_frame("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
